// File: rtl/conv5x5_mac_pkg.sv
// conv_pkg: shared constants, datapath widths and FSM state type for the
// 5x5 convolution MAC (conv5x5_mac, conv5x5_dot, conv5x5_mac_if).
package conv_pkg;

   localparam int K         = 5;
   localparam int NTAP      = K * K;
   localparam int IN_W      = 32;
   localparam int OUT_W     = 28;
   localparam int FRAME_PIX = OUT_W * OUT_W;   // 784

   localparam int PROD_W = 16;
   localparam int ROW_W  = 19;
   localparam int ACC_W  = 21;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD_W = 2'd1,
      ST_RUN    = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

endpackage

// File: rtl/conv5x5_mac_if.sv
// conv5x5_mac_if: window stream in, pixel stream out.
//   window side : i_win_valid / o_win_ready, i_win (25 x int8), row markers
//   pixel side  : o_pix_valid / i_pix_ready, o_pix, o_row, o_col, o_row_last
// slave  = the MAC, master = whoever drives windows and consumes pixels.
interface conv5x5_mac_if;
   import conv_pkg::*;

   logic                  i_win_valid;
   logic                  o_win_ready;
   logic [NTAP*8-1:0]     i_win;
   logic                  i_row_start;
   logic                  i_row_end;

   logic                  o_pix_valid;
   logic                  i_pix_ready;
   logic signed [7:0]     o_pix;
   logic [4:0]            o_row;
   logic [4:0]            o_col;
   logic                  o_row_last;

   modport slave (
      input  i_win_valid, i_win, i_row_start, i_row_end, i_pix_ready,
      output o_win_ready, o_pix_valid, o_pix, o_row, o_col, o_row_last
   );

   modport master (
      output i_win_valid, i_win, i_row_start, i_row_end, i_pix_ready,
      input  o_win_ready, o_pix_valid, o_pix, o_row, o_col, o_row_last
   );

endinterface

// File: rtl/conv5x5_dot.sv
// conv5x5_dot: first two pipeline stages of the 5x5 MAC.
//   S1: 25 signed 8x8 products (PROD_W each)
//   S2: five row sums of five products (ROW_W each)
// Ports: clk, reset (sync, active high), en (advance both stages),
//        weights / win (25 x int8, tap r*5+c at bits [(r*5+c)*8 +: 8]),
//        row_sums (5 x ROW_W, row r at bits [r*ROW_W +: ROW_W]).
module conv5x5_dot
   import conv_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [NTAP*8-1:0]     weights,
   input  logic [NTAP*8-1:0]     win,
   output logic [K*ROW_W-1:0]    row_sums
);

   logic signed [PROD_W-1:0] prod_d [NTAP];
   logic signed [PROD_W-1:0] prod_q [NTAP];
   logic signed [ROW_W-1:0]  row_d  [K];
   logic signed [ROW_W-1:0]  row_q  [K];

   always_comb begin
      for (int i = 0; i < NTAP; i++) begin
         prod_d[i] = PROD_W'($signed(weights[i*8 +: 8])) * PROD_W'($signed(win[i*8 +: 8]));
      end
      for (int r = 0; r < K; r++) begin
         row_d[r] = '0;
         for (int c = 0; c < K; c++) begin
            row_d[r] = row_d[r] + ROW_W'(prod_q[r*K + c]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NTAP; i++) prod_q[i] <= '0;
         for (int r = 0; r < K; r++)    row_q[r]  <= '0;
      end else if (en) begin
         for (int i = 0; i < NTAP; i++) prod_q[i] <= prod_d[i];
         for (int r = 0; r < K; r++)    row_q[r]  <= row_d[r];
      end
   end

   for (genvar r = 0; r < K; r++) begin : g_out
      assign row_sums[r*ROW_W +: ROW_W] = row_q[r];
   end

endmodule

// File: rtl/conv5x5_mac.sv
// conv5x5_mac: 5x5 int8 convolution MAC for a 28x28 output frame.
// Loads 25 weights, then consumes 784 windows and emits 784 int8 pixels
// (bias add, round, arithmetic shift by SHIFT, saturate, optional ReLU).
// Ports: clk, reset (sync, active high), i_start / i_bias (frame start),
//        i_w_valid / i_w_data (weight beats), o_done (frame-end pulse),
//        o_err (sticky row-marker misalignment), bus (window/pixel streams).
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for i_start
// LOAD_W   | taking 25 weight beats, index r*5+c
// RUN      | accepting windows until the 784th
// DRAIN    | flushing the pipeline until the 784th output
module conv5x5_mac
   import conv_pkg::*;
#(
   parameter int SHIFT = 7,
   parameter int RELU  = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_start,
   input  logic          i_w_valid,
   input  logic [7:0]    i_w_data,
   input  logic [15:0]   i_bias,
   output logic          o_done,
   output logic          o_err,
   conv5x5_mac_if.slave  bus
);

   localparam int SUM_W = ACC_W + 1;
   localparam int RND_I = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;
   localparam logic signed [SUM_W-1:0] RND    = SUM_W'(RND_I);
   localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(127);
   localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-128);
   localparam logic [4:0] W_LAST   = 5'(NTAP - 1);
   localparam logic [4:0] COL_LAST = 5'(OUT_W - 1);
   localparam logic [9:0] CNT_LAST = 10'(FRAME_PIX - 1);

   state_t state_q, state_d;
   logic   done_d;

   logic [NTAP*8-1:0]    w_q;
   logic [4:0]           w_idx;
   logic signed [15:0]   bias_q;
   logic [4:0]           in_col;
   logic [9:0]           in_cnt;
   logic [4:0]           out_row, out_col;
   logic                 v1, v2, pix_valid_q;
   logic signed [7:0]    pix_q;
   logic                 done_q, err_q;

   logic                 start_go, stage_en, win_ready, win_hs, pix_hs;
   logic                 w_last, in_last, out_last;
   logic [K*ROW_W-1:0]   row_flat;
   logic signed [ACC_W-1:0] acc;
   logic signed [SUM_W-1:0] rnd, shifted;
   logic signed [7:0]    pix_d;

   assign start_go  = i_start && (state_q == ST_IDLE);
   // Every stage advances together; a stalled output freezes the whole pipe.
   assign stage_en  = !pix_valid_q || bus.i_pix_ready;
   assign win_ready = (state_q == ST_RUN) && stage_en;
   assign win_hs    = bus.i_win_valid && win_ready;
   assign pix_hs    = pix_valid_q && bus.i_pix_ready;
   assign w_last    = (state_q == ST_LOAD_W) && i_w_valid && (w_idx == W_LAST);
   assign in_last   = win_hs && (in_cnt == CNT_LAST);
   assign out_last  = pix_hs && (out_row == COL_LAST) && (out_col == COL_LAST);

   conv5x5_dot u_dot (
      .clk      (clk),
      .reset    (reset),
      .en       (stage_en),
      .weights  (w_q),
      .win      (bus.i_win),
      .row_sums (row_flat)
   );

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE:   if (i_start)  state_d = ST_LOAD_W;
         ST_LOAD_W: if (w_last)   state_d = ST_RUN;
         ST_RUN:    if (in_last)  state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (out_last) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   // S3 combinational part: total, round, shift, saturate, ReLU.
   always_comb begin
      acc = ACC_W'(bias_q);
      for (int r = 0; r < K; r++) begin
         acc = acc + ACC_W'($signed(row_flat[r*ROW_W +: ROW_W]));
      end
      rnd     = SUM_W'(acc) + RND;
      shifted = rnd >>> SHIFT;
      if (shifted > SAT_HI)      pix_d = 8'sd127;
      else if (shifted < SAT_LO) pix_d = -8'sd128;
      else                       pix_d = shifted[7:0];
      if ((RELU != 0) && pix_d[7]) pix_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         w_q         <= '0;
         w_idx       <= '0;
         bias_q      <= '0;
         in_col      <= '0;
         in_cnt      <= '0;
         out_row     <= '0;
         out_col     <= '0;
         v1          <= 1'b0;
         v2          <= 1'b0;
         pix_valid_q <= 1'b0;
         pix_q       <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         if (start_go) begin
            bias_q  <= i_bias;
            w_idx   <= '0;
            in_col  <= '0;
            in_cnt  <= '0;
            out_row <= '0;
            out_col <= '0;
            err_q   <= 1'b0;
         end
         if ((state_q == ST_LOAD_W) && i_w_valid) begin
            w_q[{w_idx, 3'b000} +: 8] <= i_w_data;
            w_idx                     <= w_idx + 5'd1;
         end
         if (win_hs) begin
            if ((bus.i_row_start && (in_col != '0)) || (bus.i_row_end && (in_col != COL_LAST)))
               err_q <= 1'b1;
            in_col <= (in_col == COL_LAST) ? '0 : in_col + 5'd1;
            in_cnt <= in_cnt + 10'd1;
         end
         if (stage_en) begin
            v1          <= win_hs;
            v2          <= v1;
            pix_valid_q <= v2;
            if (v2) pix_q <= pix_d;
         end
         if (pix_hs) begin
            if (out_col == COL_LAST) begin
               out_col <= '0;
               out_row <= (out_row == COL_LAST) ? '0 : out_row + 5'd1;
            end else begin
               out_col <= out_col + 5'd1;
            end
         end
      end
   end

   assign bus.o_win_ready = win_ready;
   assign bus.o_pix_valid = pix_valid_q;
   assign bus.o_pix       = pix_q;
   assign bus.o_row       = out_row;
   assign bus.o_col       = out_col;
   assign bus.o_row_last  = pix_valid_q && (out_col == COL_LAST);
   assign o_done          = done_q;
   assign o_err           = err_q;

endmodule

// File: doc/conv5x5_mac.md
CONV5X5_MAC -- requirements
Module: conv5x5_mac

Interface
REQ-001 Parameter SHIFT, default 7, arithmetic right-shift applied to the accumulated sum (0..15).
REQ-002 Parameter RELU, default 1, clamps negative results to 0 when 1.
REQ-003 Ports, listed as name, direction, width, meaning:
- clk  in  1  the single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- i_start  in  1  begins a frame; honoured only in IDLE.
- i_w_valid  in  1  qualifies i_w_data.
- i_w_data  in  8  signed weight; 25 beats, row-major (r*5+c).
- i_bias  in  16  signed bias; sampled on the i_start cycle.
- i_win_valid  in  1  qualifies a window from the line-buffer stage.
- o_win_ready  out  1  window accepted when both valid and ready are high.
- i_win  in  200  window w[r][c] at bits [(r*5+c)*8 +: 8], signed.
- i_row_start  in  1  marks the first window of an output row.
- i_row_end  in  1  marks the last window of an output row.
- o_pix_valid  out  1  qualifies o_pix.
- i_pix_ready  in  1  downstream accept.
- o_pix  out  8  signed int8 result.
- o_row  out  5  output row (0..27) of o_pix.
- o_col  out  5  output column (0..27) of o_pix.
- o_row_last  out  1  high with o_pix when o_col==27.
- o_done  out  1  one-cycle pulse at frame end.
- o_err  out  1  sticky alignment-error flag.

Function
REQ-004 FSM states IDLE, LOAD_W, RUN, DRAIN. IDLE->LOAD_W on i_start. LOAD_W->RUN after the 25th i_w_valid beat. RUN->DRAIN when the 784th window is accepted. DRAIN->IDLE on the 784th output handshake.
REQ-005 In LOAD_W, each i_w_valid beat writes weight index 0..24; beats in any other state are ignored.
REQ-006 o_win_ready = (state==RUN) && stage_en, where stage_en = !o_pix_valid || i_pix_ready.
REQ-007 Pipeline is 3 stages, all advancing only on stage_en:
- S1: 25 signed 8x8 products, 16 bit each.
- S2: five row sums, 19 bit each.
- S3: total + bias, 21 bit, then round, shift, saturate and ReLU.
REQ-008 Latency is 3 cycles from window handshake to o_pix_valid when not stalled; throughput is 1 window per cycle.
REQ-009 Rounding: add 1<<(SHIFT-1) when SHIFT>0, then arithmetic shift right by SHIFT.
REQ-010 Saturate the shifted result to [-128,127]; if RELU=1, force negative results to 0 after saturation.
REQ-011 While i_pix_ready is low, o_pix, o_row and o_col hold stable; no window is accepted and no window is lost.
REQ-012 Input column counter counts 0..27 and wraps to 0. o_err sets if i_row_start arrives with input col!=0 or i_row_end with col!=27; it clears only on reset or i_start.
REQ-013 Output o_col counts 0..27 and wraps to 0, incrementing o_row; both advance on the output handshake.
REQ-014 o_done pulses on the cycle after the 784th output handshake.
REQ-015 i_start outside IDLE is ignored. A new i_start requires reloading all 25 weights.

Reset
REQ-016 Reset, synchronous active-high, sets state=IDLE and clears all pipeline valids, weights, bias, counters and o_err.
REQ-017 Every output resets to 0, including o_win_ready=0 and o_done=0.
REQ-018 Reset mid-RUN discards in-flight data; no o_pix_valid appears until the next frame.

Structure
REQ-019 Shared package conv_pkg holds:
- constants K=5, IN_W=32, OUT_W=28, FRAME_PIX=784;
- widths PROD_W=16, ROW_W=19, ACC_W=21;
- the FSM state enum.
REQ-020 Sub-module conv5x5_dot contains the S1/S2 multiply and row-sum pipeline with an enable input; conv5x5_mac contains the FSM, S3, counters and flags.

Verification
REQ-021 SHIFT=0, RELU=0, weights all 1, bias 0, window all 1 -> o_pix=25 exactly 3 cycles after handshake.
REQ-022 SHIFT=7, weights all 127, window all 127, bias 0 -> sum 403225, rounded and shifted 3150 -> o_pix=127 (saturated).
REQ-023 SHIFT=0, weights all -1, window all 10 -> -250 -> o_pix=-128 with RELU=0; o_pix=0 with RELU=1.
REQ-024 784-window streaming frame with i_pix_ready held low for 5 cycles mid-frame -> o_win_ready low for those cycles; 784 outputs delivered in order with correct o_row/o_col; wrap 27->0; o_done single pulse; o_err=0.
REQ-025 i_row_start asserted at input col 3 -> o_err=1 and it stays 1 until i_start.
REQ-026 Reset asserted mid-RUN -> next cycle state=IDLE, all outputs 0; the following frame works only after a fresh 25-beat weight load.
